// File: rtl/pc_jump_ctrl_pkg.sv
// Shared definitions for the PC sequencer: instruction codes, FSM states
// and the default reset/exception addresses.
package pc_jump_ctrl_pkg;

  localparam logic [7:0] INST_INVALID = 8'h00;
  localparam logic [7:0] INST_J       = 8'h02;
  localparam logic [7:0] INST_JAL     = 8'h03;
  localparam logic [7:0] INST_JR      = 8'h08;
  localparam logic [7:0] INST_JALR    = 8'h09;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    PCC_BOOT  = 2'd0,
    PCC_RUN   = 2'd1,
    PCC_DSLOT = 2'd2
  } pcc_state_e;

endpackage

// File: rtl/pc_jump_ctrl_if.sv
// Fetch handshake between the PC sequencer and the instruction-fetch stage.
// if_req is the valid, if_ack the ready; pc is consumed when both are high
// in a cycle without stall.
interface pc_jump_ctrl_if;
  logic [31:0] pc;
  logic        if_req;
  logic        if_ack;
  logic        in_dslot;

  modport master (output pc, output if_req, output in_dslot, input if_ack);
  modport slave  (input pc, input if_req, input in_dslot, output if_ack);
endinterface

// File: rtl/pc_jump_ctrl_target.sv
// Combinational jump decode: classifies J/JAL/JR/JALR and forms the target.
// Kept separate so the branch unit can reuse it.
module jump_target_calc
  import pc_jump_ctrl_pkg::*;
(
  input  logic [7:0]  id_inst,
  input  logic [31:0] id_pc,
  input  logic [25:0] id_addr,
  input  logic [31:0] id_rs_val,
  output logic        is_jump,
  output logic        is_link,
  output logic [31:0] pc_plus4,
  output logic [31:0] target
);

  logic w_is_reg;

  always_comb begin
    pc_plus4 = id_pc + 32'd4;
    w_is_reg = (id_inst == INST_JR) || (id_inst == INST_JALR);
    is_link  = (id_inst == INST_JAL) || (id_inst == INST_JALR);
    is_jump  = w_is_reg || (id_inst == INST_J) || (id_inst == INST_JAL);
    // J-format region comes from the delay-slot PC, not the jump's own PC
    target   = w_is_reg ? id_rs_val : {pc_plus4[31:28], id_addr, 2'b00};
  end

endmodule

// File: rtl/pc_jump_ctrl.sv
// Fetch-PC sequencer: steps the PC on accepted fetches, redirects for
// register/immediate jumps after the delay slot, and takes exception redirects.
module pc_jump_ctrl
  import pc_jump_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [7:0]        id_inst,
  input  logic [25:0]       id_addr,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_rs_val,
  input  logic              exc_flush,
  input  logic [31:0]       exc_vector,
  pc_jump_ctrl_if.master    fetch,
  output logic [31:0]       link_addr,
  output logic              link_en,
  output logic [1:0]        dbg_state,
  output logic [31:0]       dbg_tgt
);

  pcc_state_e        r_state, w_state_n;
  logic [ADDR_W-1:0] r_pc, w_pc_n;
  logic [ADDR_W-1:0] r_tgt, w_tgt_n;
  logic              r_in_dslot, w_dslot_n;

  logic        w_is_jump, w_is_link;
  logic [31:0] w_pc_plus4, w_target;
  logic        w_if_req, w_accept, w_jump;

  jump_target_calc u_target (
    .id_inst   (id_inst),
    .id_pc     (id_pc),
    .id_addr   (id_addr),
    .id_rs_val (id_rs_val),
    .is_jump   (w_is_jump),
    .is_link   (w_is_link),
    .pc_plus4  (w_pc_plus4),
    .target    (w_target)
  );

  assign w_if_req = (r_state != PCC_BOOT);
  assign w_accept = w_if_req && fetch.if_ack && !stall;
  assign w_jump   = w_is_jump && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= PCC_BOOT;
      r_pc       <= RESET_PC;
      r_tgt      <= '0;
      r_in_dslot <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      r_tgt      <= w_tgt_n;
      r_in_dslot <= w_dslot_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_tgt_n   = r_tgt;
    w_dslot_n = r_in_dslot;
    if (exc_flush) begin
      w_pc_n    = exc_vector;
      w_state_n = PCC_RUN;
      w_tgt_n   = '0;
      w_dslot_n = 1'b0;
    end else begin
      case (r_state)
        PCC_BOOT: w_state_n = PCC_RUN;
        PCC_RUN: begin
          if (w_jump && w_accept) begin
            // the fetch going out now is the delay slot itself
            w_pc_n = w_target;
          end else if (w_jump) begin
            w_tgt_n   = w_target;
            w_state_n = PCC_DSLOT;
            w_dslot_n = 1'b1;
          end else if (w_accept) begin
            w_pc_n = r_pc + ADDR_W'(4);
          end
        end
        PCC_DSLOT: begin
          // jumps decoded here sit in a delay slot and are ignored
          if (w_accept) begin
            w_pc_n    = r_tgt;
            w_state_n = PCC_RUN;
            w_dslot_n = 1'b0;
          end
        end
        default: w_state_n = PCC_BOOT;
      endcase
    end
  end

  assign fetch.pc       = r_pc;
  assign fetch.if_req   = w_if_req;
  assign fetch.in_dslot = r_in_dslot;
  assign link_addr      = w_pc_plus4 + 32'd4;
  assign link_en        = w_is_link && !stall;
  assign dbg_state      = r_state;
  assign dbg_tgt        = r_tgt;

endmodule

// File: tb/tb_pc_jump_ctrl.sv
// Bench for pc_jump_ctrl: a table of per-cycle vectors through a scoreboard
// queue, then a reset-during-delay-slot sequence.
module tb_pc_jump_ctrl;
  import pc_jump_ctrl_pkg::*;

  typedef struct {
    logic        stall;
    logic        ack;
    logic [7:0]  inst;
    logic [25:0] addr;
    logic [31:0] id_pc;
    logic [31:0] rs;
    logic        exc;
    logic [31:0] vec;
    logic        e_link_en;
    logic [31:0] e_pc;
    logic [31:0] e_tgt;
    logic [1:0]  e_state;
    logic        e_dslot;
    logic        e_chk_tgt;
  } vec_t;

  localparam int NV = 22;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [7:0]  id_inst = INST_INVALID;
  logic [25:0] id_addr = '0;
  logic [31:0] id_pc = '0;
  logic [31:0] id_rs_val = '0;
  logic        exc_flush = 1'b0;
  logic [31:0] exc_vector = '0;
  logic [31:0] link_addr;
  logic        link_en;
  logic [1:0]  dbg_state;
  logic [31:0] dbg_tgt;

  int checks = 0;
  int errors = 0;
  logic [67:0] exp_q[$];
  vec_t vecs[NV];

  pc_jump_ctrl_if fetch ();

  pc_jump_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .id_inst    (id_inst),
    .id_addr    (id_addr),
    .id_pc      (id_pc),
    .id_rs_val  (id_rs_val),
    .exc_flush  (exc_flush),
    .exc_vector (exc_vector),
    .fetch      (fetch),
    .link_addr  (link_addr),
    .link_en    (link_en),
    .dbg_state  (dbg_state),
    .dbg_tgt    (dbg_tgt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic s, logic a, logic [7:0] i, logic [25:0] ad,
                              logic [31:0] ip, logic [31:0] r, logic x,
                              logic [31:0] v, logic le, logic [31:0] p,
                              logic [31:0] t, logic [1:0] st, logic d, logic ct);
    vec_t o;
    o.stall = s; o.ack = a; o.inst = i; o.addr = ad; o.id_pc = ip; o.rs = r;
    o.exc = x; o.vec = v; o.e_link_en = le; o.e_pc = p; o.e_tgt = t;
    o.e_state = st; o.e_dslot = d; o.e_chk_tgt = ct;
    return o;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drive at negedge, check combinational link outputs, then registered
  // outputs just after the following posedge; returns at the next negedge
  task automatic step(int n, vec_t v);
    logic [67:0] e;
    stall = v.stall; fetch.if_ack = v.ack; id_inst = v.inst; id_addr = v.addr;
    id_pc = v.id_pc; id_rs_val = v.rs; exc_flush = v.exc; exc_vector = v.vec;
    #1;
    chk($sformatf("s%0d link_en", n), {31'd0, link_en}, {31'd0, v.e_link_en});
    chk($sformatf("s%0d link_addr", n), link_addr, v.id_pc + 32'd8);
    exp_q.push_back({v.e_pc, v.e_tgt, v.e_state, v.e_dslot, v.e_chk_tgt});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk($sformatf("s%0d pc", n), fetch.pc, e[67:36]);
    chk($sformatf("s%0d state", n), {30'd0, dbg_state}, {30'd0, e[3:2]});
    chk($sformatf("s%0d in_dslot", n), {31'd0, fetch.in_dslot}, {31'd0, e[1]});
    chk($sformatf("s%0d if_req", n), {31'd0, fetch.if_req},
        {31'd0, e[3:2] != PCC_BOOT});
    if (e[0]) chk($sformatf("s%0d tgt", n), dbg_tgt, e[35:4]);
    @(negedge clk);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, " pc"}, fetch.pc, 32'hBFC0_0000);
    chk({tag, " if_req"}, {31'd0, fetch.if_req}, 32'd0);
    chk({tag, " in_dslot"}, {31'd0, fetch.in_dslot}, 32'd0);
    chk({tag, " state"}, {30'd0, dbg_state}, {30'd0, PCC_BOOT});
    chk({tag, " tgt"}, dbg_tgt, 32'd0);
  endtask

  initial begin
    fetch.if_ack = 1'b0;
    //            stl ack inst          addr        id_pc          rs             exc vec            le  pc             tgt            state      ds ct
    vecs[0]  = mk(0, 1, INST_INVALID, 26'h0,      32'h0,         32'h0,         0, 32'h0,         0, 32'hBFC00000, 32'h0,         PCC_RUN,   0, 1);
    vecs[1]  = mk(0, 1, INST_INVALID, 26'h0,      32'h0,         32'h0,         0, 32'h0,         0, 32'hBFC00004, 32'h0,         PCC_RUN,   0, 1);
    vecs[2]  = mk(0, 1, INST_INVALID, 26'h0,      32'h0,         32'h0,         0, 32'h0,         0, 32'hBFC00008, 32'h0,         PCC_RUN,   0, 1);
    vecs[3]  = mk(0, 1, INST_J,       26'h100,    32'hBFC00004,  32'h0,         0, 32'h0,         0, 32'hB0000400, 32'h0,         PCC_RUN,   0, 1);
    vecs[4]  = mk(0, 0, INST_INVALID, 26'h0,      32'h0,         32'h0,         1, 32'hBFC00008,  0, 32'hBFC00008, 32'h0,         PCC_RUN,   0, 0);
    vecs[5]  = mk(0, 0, INST_J,       26'h100,    32'hBFC00004,  32'h0,         0, 32'h0,         0, 32'hBFC00008, 32'hB0000400, PCC_DSLOT, 1, 1);
    vecs[6]  = mk(0, 0, INST_J,       26'h200,    32'hBFC00008,  32'h0,         0, 32'h0,         0, 32'hBFC00008, 32'hB0000400, PCC_DSLOT, 1, 1);
    vecs[7]  = mk(0, 1, INST_INVALID, 26'h0,      32'h0,         32'h0,         0, 32'h0,         0, 32'hB0000400, 32'hB0000400, PCC_RUN,   0, 1);
    vecs[8]  = mk(0, 1, INST_JALR,    26'h0,      32'h80000010,  32'h80001230,  0, 32'h0,         1, 32'h80001230, 32'hB0000400, PCC_RUN,   0, 1);
    vecs[9]  = mk(0, 0, INST_JR,      26'h0,      32'h80000014,  32'h12345679,  0, 32'h0,         0, 32'h80001230, 32'h12345679, PCC_DSLOT, 1, 1);
    vecs[10] = mk(1, 0, INST_INVALID, 26'h0,      32'h0,         32'h0,         1, 32'hBFC00380,  0, 32'hBFC00380, 32'h0,         PCC_RUN,   0, 0);
    vecs[11] = mk(0, 1, INST_INVALID, 26'h0,      32'h0,         32'h0,         0, 32'h0,         0, 32'hBFC00384, 32'h0,         PCC_RUN,   0, 0);
    vecs[12] = mk(0, 1, INST_INVALID, 26'h0,      32'h0,         32'h0,         0, 32'h0,         0, 32'hBFC00388, 32'h0,         PCC_RUN,   0, 0);
    vecs[13] = mk(1, 1, INST_JAL,     26'h3,      32'h0,         32'h0,         0, 32'h0,         0, 32'hBFC00388, 32'h0,         PCC_RUN,   0, 0);
    vecs[14] = mk(0, 0, INST_JR,      26'h0,      32'h0,         32'h40,        0, 32'h0,         0, 32'hBFC00388, 32'h40,        PCC_DSLOT, 1, 1);
    vecs[15] = mk(1, 1, INST_JALR,    26'h0,      32'h100,       32'h80,        0, 32'h0,         0, 32'hBFC00388, 32'h40,        PCC_DSLOT, 1, 1);
    vecs[16] = mk(0, 1, INST_INVALID, 26'h0,      32'h0,         32'h0,         0, 32'h0,         0, 32'h00000040, 32'h40,        PCC_RUN,   0, 1);
    vecs[17] = mk(0, 1, INST_INVALID, 26'h0,      32'h0,         32'h0,         1, 32'hFFFFFFF8,  0, 32'hFFFFFFF8, 32'h0,         PCC_RUN,   0, 0);
    vecs[18] = mk(0, 1, INST_INVALID, 26'h0,      32'h0,         32'h0,         0, 32'h0,         0, 32'hFFFFFFFC, 32'h0,         PCC_RUN,   0, 0);
    vecs[19] = mk(0, 1, INST_INVALID, 26'h0,      32'h0,         32'h0,         0, 32'h0,         0, 32'h00000000, 32'h0,         PCC_RUN,   0, 0);
    vecs[20] = mk(0, 1, INST_JAL,     26'h3FFFFFF, 32'h00400000, 32'h0,         0, 32'h0,         1, 32'h0FFFFFFC, 32'h0,         PCC_RUN,   0, 0);
    vecs[21] = mk(0, 1, INST_JAL,     26'h1,      32'hEFFFFFFC,  32'h0,         0, 32'h0,         1, 32'hF0000004, 32'h0,         PCC_RUN,   0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NV; i++) step(i, vecs[i]);

    // reset while a target is pending in the delay slot
    step(100, mk(0, 0, INST_JR, 26'h0, 32'h0, 32'h0000_2000, 0, 32'h0, 0,
                 32'hF0000004, 32'h0000_2000, PCC_DSLOT, 1, 1));
    #2;
    rst = 1'b1;
    #1;
    chk_reset("rst_dslot");
    @(negedge clk);
    rst = 1'b0;
    step(101, mk(0, 1, INST_INVALID, 26'h0, 32'h0, 32'h0, 0, 32'h0, 0,
                 32'hBFC00000, 32'h0, PCC_RUN, 0, 1));
    step(102, mk(0, 1, INST_INVALID, 26'h0, 32'h0, 32'h0, 0, 32'h0, 0,
                 32'hBFC00004, 32'h0, PCC_RUN, 0, 1));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_jump_ctrl.md
Name: pc_jump_ctrl

Overview:
- Program-counter sequencer for the 5-stage MIPS core.
- Owns the fetch PC and drives fetch requests to the instruction-fetch stage.
- Redirects the PC for J/JAL/JR/JALR decoded in ID, honouring the MIPS branch delay slot.
- Applies exception redirects with top priority and reports the delay-slot flag and link address.

Parameters:
- RESET_PC, 32'hBFC00000, fetch address after reset.
- ADDR_W, 32, PC width; fixed at 32, kept for clarity.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline stall; freezes the PC and ID sampling.
- if_ack  in  1  fetch stage accepted the current pc this cycle.
- id_inst  in  8  decoded instruction code from ID (INST_* values).
- id_addr  in  26  J-format target field from ID.
- id_pc  in  32  PC of the instruction in ID.
- id_rs_val  in  32  forwarded rs value for JR/JALR.
- exc_flush  in  1  exception/ERET redirect request.
- exc_vector  in  32  redirect address for exc_flush.
- pc  out  32  current fetch address.
- if_req  out  1  fetch request valid.
- in_dslot  out  1  the instruction at pc is a delay slot.
- link_addr  out  32  id_pc+8, for JAL/JALR writeback.
- link_en  out  1  id_inst is JAL or JALR and !stall.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, if_req=0, in_dslot=0, tgt_q=0, state=BOOT.
  - link_addr and link_en are combinational from inputs.
- States:
  - BOOT: if_req=0. Next cycle goes to RUN unconditionally.
  - RUN: normal fetch, if_req=1.
  - DSLOT: jump target pending, delay slot not yet accepted; if_req=1, in_dslot=1.
- Definitions:
  - accept = if_req & if_ack & !stall.
  - jump = !stall & id_inst ∈ {INST_J, INST_JAL, INST_JR, INST_JALR}.
- Jump target, computed combinationally from the decode inputs:
  - J/JAL: {id_pc_plus4[31:28], id_addr, 2'b00}, where id_pc_plus4 = id_pc+4, i.e. the delay-slot PC.
  - JR/JALR: id_rs_val. Bits [1:0] are passed through unchanged; misalignment is the fetch stage's exception.
- Priority each cycle:
  1. exc_flush: pc<=exc_vector, state<=RUN, tgt_q discarded, in_dslot<=0. Ignores stall, if_ack and jump.
  2. RUN, jump & accept: the fetch being accepted is the delay slot, so pc<=target and state stays RUN.
  3. RUN, jump & !accept: tgt_q<=target, state<=DSLOT, pc unchanged.
  4. RUN, accept only: pc<=pc+4 (32-bit wrap, FFFFFFFC→00000000).
  5. DSLOT, accept: pc<=tgt_q, state<=RUN.
  6. DSLOT, jump: ignored, because a jump in a delay slot is architecturally undefined. tgt_q is kept.
  7. Otherwise: hold.
- in_dslot is registered:
  - Set by a RUN→DSLOT transition.
  - Cleared on leaving DSLOT or on flush.
- Latency:
  - A jump decoded at edge N is visible as pc=target at edge N+1 when the delay slot is accepted in the same cycle.
  - Otherwise it is visible one cycle after the accept.
- stall=1 with no flush: all registers hold.
- rst asserted mid-DSLOT: the pending target is lost and the core returns to BOOT.

Decomposition:
- Shared defs.v:
  - INST_J, INST_JAL, INST_JR, INST_JALR, INST_INVALID codes.
  - PCC_BOOT/RUN/DSLOT 2-bit state encodings.
  - Default RESET_PC and exception vector constants.
- Sub-module jump_target_calc (combinational): id_inst, id_pc, id_addr, id_rs_val → is_jump, is_link, target. Reused by the branch unit later.

Test Plan:
- Reset release → pc=BFC00000, if_req=0 for 1 cycle, then if_req=1; with if_ack=1 every cycle pc steps BFC00004, BFC00008.
- RUN, pc=BFC00008, id_inst=INST_J, id_pc=BFC00004, id_addr=0x0000100, if_ack=1 → next pc=B0000400, in_dslot=0, link_en=0.
- Same J with if_ack=0 for 2 cycles → state DSLOT, in_dslot=1, pc holds BFC00008. The ack then gives pc=B0000400 and in_dslot=0.
- JALR, id_rs_val=80001230, id_pc=80000010, if_ack=1 → link_addr=80000018, link_en=1, next pc=80001230.
- DSLOT pending with exc_flush=1, exc_vector=BFC00380, stall=1 in the same cycle → pc=BFC00380, state RUN, in_dslot=0; later accepts step from BFC00384, not the old target.
- pc=FFFFFFFC with accept → pc=00000000. stall=1 with a jump on id_inst → no state, pc or tgt_q change.
